// File: rtl/opti_iir_cascade_tdm_if.sv
// Sample stream bundle for the TDM biquad cascade: input handshake with bypass tag,
// and the held-until-accepted output handshake.
interface opti_iir_cascade_tdm_if #(
  parameter int DATA_W = 16
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              bypass;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, bypass, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, bypass, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/opti_iir_cascade_tdm.sv
// Cascade of N_STAGES Direct-Form-I biquads sharing one multiply-accumulate engine,
// five taps plus one write-back cycle per stage, with run-time coefficient writes.
module opti_iir_cascade_tdm #(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int FRAC_W   = 14,
  parameter int N_STAGES = 6,
  parameter int ACC_W    = 40
) (
  input  logic                     clk,
  input  logic                     rst_n,
  opti_iir_cascade_tdm_if.slave    io,
  input  logic                     clear_state,
  input  logic                     coef_wr_en,
  input  logic [2:0]               coef_wr_stage,
  input  logic [2:0]               coef_wr_sel,
  input  logic signed [COEF_W-1:0] coef_wr_data,
  output logic                     coef_wr_err,
  output logic                     busy,
  output logic                     sat_flag
);

  localparam int PW = DATA_W + COEF_W;
  localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1 << FRAC_W);
  localparam logic signed [ACC_W-1:0]  RND      = ACC_W'(1) <<< (FRAC_W - 1);
  localparam logic signed [ACC_W-1:0]  Y_MAX    = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  Y_MIN    = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB, S_OUT} state_t;

  state_t                    state_reg;
  logic [2:0]                stage_reg;
  logic [2:0]                tap_reg;
  logic signed [ACC_W-1:0]   acc_reg;
  logic signed [DATA_W-1:0]  x_cur_reg;
  logic [DATA_W-1:0]         out_data_reg;
  logic                      out_valid_reg;
  logic                      sat_flag_reg;
  logic                      coef_wr_err_reg;

  logic                      idle;
  logic                      clear_now;
  logic                      wr_ok;
  logic                      hist_upd;

  logic signed [DATA_W-1:0]  x1_all [N_STAGES];
  logic signed [DATA_W-1:0]  x2_all [N_STAGES];
  logic signed [DATA_W-1:0]  y1_all [N_STAGES];
  logic signed [DATA_W-1:0]  y2_all [N_STAGES];
  logic signed [COEF_W-1:0]  coef_all [N_STAGES][5];

  logic signed [COEF_W-1:0]  coef_cur;
  logic signed [DATA_W-1:0]  oper_cur;
  logic signed [PW-1:0]      prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   acc_base;
  logic signed [ACC_W-1:0]   acc_next;
  logic signed [ACC_W-1:0]   acc_rnd;
  logic signed [ACC_W-1:0]   acc_shift;
  logic signed [DATA_W-1:0]  y_sat;
  logic                      sat_hit;

  assign idle      = (state_reg == S_IDLE);
  assign clear_now = idle && clear_state;
  assign hist_upd  = (state_reg == S_WB);
  assign wr_ok     = coef_wr_en && idle && (int'(coef_wr_stage) < N_STAGES) && (coef_wr_sel < 3'd5);

  // Per-stage history and coefficient registers; the engine reads them through the
  // flattened arrays indexed by the current stage and tap.
  generate
    for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_stage
      logic signed [DATA_W-1:0] x1_q, x2_q, y1_q, y2_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          x1_q <= '0;
          x2_q <= '0;
          y1_q <= '0;
          y2_q <= '0;
        end else if (clear_now) begin
          x1_q <= '0;
          x2_q <= '0;
          y1_q <= '0;
          y2_q <= '0;
        end else if (hist_upd && stage_reg == 3'(gi)) begin
          x2_q <= x1_q;
          x1_q <= x_cur_reg;
          y2_q <= y1_q;
          y1_q <= y_sat;
        end
      end

      assign x1_all[gi] = x1_q;
      assign x2_all[gi] = x2_q;
      assign y1_all[gi] = y1_q;
      assign y2_all[gi] = y2_q;

      for (genvar gj = 0; gj < 5; gj++) begin : g_coef
        logic signed [COEF_W-1:0] c_q;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            c_q <= (gj == 0) ? COEF_ONE : '0;
          end else if (wr_ok && coef_wr_stage == 3'(gi) && coef_wr_sel == 3'(gj)) begin
            c_q <= coef_wr_data;
          end
        end

        assign coef_all[gi][gj] = c_q;
      end
    end
  endgenerate

  // Tap order b0*x, b1*x1, b2*x2, then the feedback terms a1*y1, a2*y2 subtracted.
  always_comb begin
    coef_cur = coef_all[stage_reg][tap_reg];
    case (tap_reg)
      3'd0:    oper_cur = x_cur_reg;
      3'd1:    oper_cur = x1_all[stage_reg];
      3'd2:    oper_cur = x2_all[stage_reg];
      3'd3:    oper_cur = y1_all[stage_reg];
      default: oper_cur = y2_all[stage_reg];
    endcase
  end

  assign prod     = PW'(coef_cur) * PW'(oper_cur);
  assign prod_ext = ACC_W'(prod);
  assign acc_base = (tap_reg == 3'd0) ? '0 : acc_reg;
  assign acc_next = (tap_reg >= 3'd3) ? (acc_base - prod_ext) : (acc_base + prod_ext);

  assign acc_rnd   = acc_reg + RND;
  assign acc_shift = acc_rnd >>> FRAC_W;
  assign sat_hit   = (acc_shift > Y_MAX) || (acc_shift < Y_MIN);

  always_comb begin
    if (acc_shift > Y_MAX) begin
      y_sat = Y_MAX[DATA_W-1:0];
    end else if (acc_shift < Y_MIN) begin
      y_sat = Y_MIN[DATA_W-1:0];
    end else begin
      y_sat = acc_shift[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      stage_reg       <= '0;
      tap_reg         <= '0;
      acc_reg         <= '0;
      x_cur_reg       <= '0;
      out_data_reg    <= '0;
      out_valid_reg   <= 1'b0;
      sat_flag_reg    <= 1'b0;
      coef_wr_err_reg <= 1'b0;
    end else begin
      coef_wr_err_reg <= coef_wr_en && !idle;
      case (state_reg)
        S_IDLE: begin
          if (clear_state) begin
            sat_flag_reg <= 1'b0;
          end
          if (io.in_valid) begin
            if (io.bypass) begin
              out_data_reg  <= io.in_data;
              out_valid_reg <= 1'b1;
              state_reg     <= S_OUT;
            end else begin
              x_cur_reg <= io.in_data;
              stage_reg <= '0;
              tap_reg   <= '0;
              state_reg <= S_MAC;
            end
          end
        end
        S_MAC: begin
          acc_reg <= acc_next;
          if (tap_reg == 3'd4) begin
            state_reg <= S_WB;
          end else begin
            tap_reg <= tap_reg + 3'd1;
          end
        end
        S_WB: begin
          // The stage result becomes the next stage's input sample.
          x_cur_reg <= y_sat;
          if (sat_hit) begin
            sat_flag_reg <= 1'b1;
          end
          if (stage_reg == 3'(N_STAGES - 1)) begin
            out_data_reg  <= y_sat;
            out_valid_reg <= 1'b1;
            state_reg     <= S_OUT;
          end else begin
            stage_reg <= stage_reg + 3'd1;
            tap_reg   <= '0;
            state_reg <= S_MAC;
          end
        end
        default: begin
          if (io.out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign io.in_ready  = idle;
  assign io.out_valid = out_valid_reg;
  assign io.out_data  = out_data_reg;
  assign busy         = !idle;
  assign sat_flag     = sat_flag_reg;
  assign coef_wr_err  = coef_wr_err_reg;

endmodule
